// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator (I/U/S/B/J/Z) for the decode stage.
// Valid/ready on both sides; SKID selects a 2-entry skid buffer or a single register.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            ill;
    } ent_t;

    function automatic ent_t decode(input logic [31:0] ins,
                                    input logic [2:0]  src);
        logic [31:0] v;
        ent_t        e;
        v     = '0;
        e.ill = 1'b0;
        case (src)
            3'b000: v = {{20{ins[31]}}, ins[31:20]};
            3'b001: v = {ins[31:12], 12'b0};
            3'b010: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'b011: v = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            3'b100: v = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            3'b101: v = {27'b0, ins[19:15]};
            default: e.ill = 1'b1;
        endcase
        // Z and illegal leave v[31]=0, so widening is a plain sign copy.
        e.imm       = {XLEN{v[31]}};
        e.imm[31:0] = v;
        return e;
    endfunction

    ent_t out_q, out_d;
    logic out_v_q, out_v_d;
    ent_t dec;
    logic accept;
    logic out_fire;
    logic unused_opc;

    assign unused_opc = ^in_instr[6:0];
    assign dec        = decode(in_instr, in_immsrc);
    assign accept     = in_valid && in_ready && !flush;
    assign out_fire   = out_v_q && out_ready;

    assign out_valid   = out_v_q;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.ill;

    if (SKID) begin : g_skid
        ent_t skid_q, skid_d;
        logic skid_v_q, skid_v_d;

        assign in_ready = !skid_v_q;

        always_comb begin
            out_v_d  = out_v_q;
            out_d    = out_q;
            skid_v_d = skid_v_q;
            skid_d   = skid_q;
            if (flush) begin
                out_v_d  = 1'b0;
                skid_v_d = 1'b0;
            end else if (!out_v_q || out_fire) begin
                if (skid_v_q) begin
                    out_v_d  = 1'b1;
                    out_d    = skid_q;
                    skid_v_d = 1'b0;
                end else begin
                    out_v_d = accept;
                    if (accept) out_d = dec;
                end
            end else if (accept) begin
                skid_v_d = 1'b1;
                skid_d   = dec;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_v_q  <= 1'b0;
                out_q    <= '0;
                skid_v_q <= 1'b0;
                skid_q   <= '0;
            end else begin
                out_v_q  <= out_v_d;
                out_q    <= out_d;
                skid_v_q <= skid_v_d;
                skid_q   <= skid_d;
            end
        end
    end else begin : g_noskid
        assign in_ready = !out_v_q || out_ready;

        always_comb begin
            out_v_d = out_v_q;
            out_d   = out_q;
            if (flush) begin
                out_v_d = 1'b0;
            end else if (accept) begin
                out_v_d = 1'b1;
                out_d   = dec;
            end else if (out_fire) begin
                out_v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_v_q <= 1'b0;
                out_q   <= '0;
            end else begin
                out_v_q <= out_v_d;
                out_q   <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit no-skid instance
// share stimulus and are each checked against a queue model every cycle.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_immsrc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_immsrc(in_immsrc),
        .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_illegal(a_out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_immsrc(in_immsrc),
        .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_illegal(b_out_illegal)
    );

    typedef struct {
        logic [63:0] imm;
        bit          ill;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t ref_dec(input logic [31:0] x,
                                     input logic [2:0]  s);
        exp_t   e;
        longint v;
        e.ill = 1'b0;
        v     = 0;
        case (s)
            3'd0: begin
                v = 64'(x[31:20]);
                if (v >= 2048) v -= 4096;
            end
            3'd1: begin
                v = 64'(x[31:12]) * 4096;
                if (x[31]) v -= 64'h1_0000_0000;
            end
            3'd2: begin
                v = 64'({x[31:25], x[11:7]});
                if (v >= 2048) v -= 4096;
            end
            3'd3: begin
                v = 64'({x[31], x[7], x[30:25], x[11:8]}) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin
                v = 64'({x[31], x[19:12], x[20], x[30:21]}) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            3'd5: v = 64'(x[19:15]);
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    function automatic void chk(input string n, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [2:0] s, input logic rdy,
                         input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_immsrc = s;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Compare against the model mid-cycle, then advance the model on the edge.
    task automatic step();
        bit   ra, rb, fa_in, fb_in, fa_out, fb_out;
        exp_t e;
        @(negedge clk);
        ra = qa.size() < 2;
        rb = (qb.size() == 0) || out_ready;
        chk("a_ready", 64'(a_in_ready), 64'(ra));
        chk("b_ready", 64'(b_in_ready), 64'(rb));
        chk("a_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        chk("b_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        chk("a_known", 64'($isunknown({a_out_imm, a_out_illegal})), 64'd0);
        chk("b_known", 64'($isunknown({b_out_imm, b_out_illegal})), 64'd0);
        if (qa.size() > 0) begin
            chk("a_imm", 64'(a_out_imm), {32'd0, qa[0].imm[31:0]});
            chk("a_ill", 64'(a_out_illegal), 64'(qa[0].ill));
        end
        if (qb.size() > 0) begin
            chk("b_imm", b_out_imm, qb[0].imm);
            chk("b_ill", 64'(b_out_illegal), 64'(qb[0].ill));
        end
        fa_in  = in_valid && ra;
        fb_in  = in_valid && rb;
        fa_out = (qa.size() > 0) && out_ready;
        fb_out = (qb.size() > 0) && out_ready;
        e = ref_dec(in_instr, in_immsrc);
        @(posedge clk);
        if (fa_out) void'(qa.pop_front());
        if (fb_out) void'(qb.pop_front());
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (fa_in) qa.push_back(e);
            if (fb_in) qb.push_back(e);
        end
        #1;
    endtask

    initial begin
        #1;
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_imm", 64'(a_out_imm), 64'd0);
        chk("rst_b_imm", b_out_imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(a_in_ready), 64'd1);

        drive(1, 32'hFFF00093, 3'd0, 1, 0); step();
        chk("t1_a_valid", 64'(a_out_valid), 64'd1);
        chk("t1_a_imm", 64'(a_out_imm), 64'hFFFF_FFFF);
        chk("t1_a_ill", 64'(a_out_illegal), 64'd0);
        chk("t1_b_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 32'hFE000EE3, 3'd3, 1, 0); step();
        chk("t2_b_type", 64'(a_out_imm), 64'hFFFF_FFFC);
        drive(1, 32'h800000B7, 3'd1, 1, 0); step();
        chk("t2_u32", 64'(a_out_imm), 64'h8000_0000);
        chk("t2_u64", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        drive(1, 32'h12345678, 3'd7, 1, 0); step();
        chk("t5_ill", 64'(a_out_illegal), 64'd1);
        chk("t5_ill_imm", 64'(a_out_imm), 64'd0);
        drive(1, 32'h800F8073, 3'd5, 1, 0); step();
        chk("t5_z_ill", 64'(a_out_illegal), 64'd0);
        chk("t5_z32", 64'(a_out_imm), 64'h1F);
        chk("t5_z64", b_out_imm, 64'h1F);
        drive(0, 32'h0, 3'd0, 1, 0); step();

        drive(1, 32'h00500093, 3'd0, 0, 0); step();
        chk("t3_first", 64'(a_out_imm), 64'h5);
        drive(1, 32'hFE112E23, 3'd2, 0, 0); step();
        chk("t3_ready_low", 64'(a_in_ready), 64'd0);
        chk("t3_hold", 64'(a_out_imm), 64'h5);
        drive(1, 32'h00700093, 3'd0, 0, 0); step();
        chk("t3_hold2", 64'(a_out_imm), 64'h5);
        drive(0, 32'h0, 3'd0, 1, 0); step();
        chk("t3_second", 64'(a_out_imm), 64'hFFFF_FFFC);
        chk("t3_ready_up", 64'(a_in_ready), 64'd1);
        step();
        chk("t3_drained", 64'(a_out_valid), 64'd0);

        drive(1, 32'h00500093, 3'd0, 0, 0); step();
        drive(1, 32'h00600093, 3'd0, 0, 1); step();
        chk("t4_valid", 64'(a_out_valid), 64'd0);
        chk("t4_ready", 64'(a_in_ready), 64'd1);
        drive(0, 32'h0, 3'd0, 1, 0);
        repeat (3) step();

        drive(1, 32'h00100093, 3'd0, 0, 0); step();
        drive(1, 32'h00200093, 3'd0, 0, 0); step();
        drive(0, 32'h0, 3'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_a_valid", 64'(a_out_valid), 64'd0);
        chk("t6_a_imm", 64'(a_out_imm), 64'd0);
        chk("t6_b_valid", 64'(b_out_valid), 64'd0);
        chk("t6_b_imm", b_out_imm, 64'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ready", 64'(a_in_ready), 64'd1);
        drive(1, 32'h00500093, 3'd0, 1, 0); step();
        chk("t6_lat_valid", 64'(a_out_valid), 64'd1);
        chk("t6_lat_imm", 64'(a_out_imm), 64'h5);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, $urandom, 3'($urandom % 8),
                  ($urandom % 3) != 0, ($urandom % 32) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It replaces the combinational I/B-only sign extender and covers all RV immediate formats (I, S, B, U, J, CSR zimm) at XLEN 32 or 64. It sits between fetch/decode and execute on a valid/ready handshake, with an optional skid buffer so that stalls do not create a combinational ready path.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
SKID, 1, selects the buffering mode.
- 1: 2-entry skid buffer with registered in_ready.
- 0: single output register with combinational in_ready.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  instruction/immsrc pair offered.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  raw instruction word.
in_immsrc  input  3  format select.
flush  input  1  synchronous pipeline flush.
out_valid  output  1  out_imm/out_illegal valid.
out_ready  input  1  execute stage accepts.
out_imm  output  XLEN  extended immediate.
out_illegal  output  1  in_immsrc was unsupported.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_imm=0, out_illegal=0, skid entry empty.
  - in_ready=1 from the first edge after release.
  - Reset mid-transfer discards all held data; nothing is replayed.
- Format decode (sext = sign-extend to XLEN from the top bit shown):
  - 000 I: sext(instr[31:20]).
  - 001 U: sext({instr[31:12],12'b0}). At XLEN=64 bits 63:32 copy instr[31].
  - 010 S: sext({instr[31:25],instr[11:7]}).
  - 011 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}). LSB is always 0.
  - 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 101 Z: zero-extend instr[19:15] (CSR immediate).
  - 110/111: out_imm=0, out_illegal=1, still delivered as a normal transfer.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready on that side.
  - Latency is 1 cycle: an input accepted at edge N is presented with out_valid=1 after edge N.
  - Throughput is 1 per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, out_imm and out_illegal hold stable. out_valid never drops without a transfer or flush.
  - Order is strictly preserved.
- SKID=1:
  - in_ready is a flop equal to "skid entry empty".
  - An input accepted while the output is stalled goes to the skid entry, and in_ready falls the next cycle.
  - When the output transfers, the skid entry moves to the output and in_ready rises the next cycle.
  - Capacity is 2 (output + skid).
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Capacity is 1.
- flush:
  - On a flush edge, out_valid becomes 0 and the skid entry is emptied.
  - Any input handshake in the same cycle is discarded.
  - Any output handshake in the same cycle still counts as completed downstream.
  - in_ready=1 after the flush.
- Simultaneous output transfer and input accept on a full output register (SKID either value): the new data replaces the output with no bubble.
- Width rules:
  - All extension is done at XLEN.
  - in_immsrc is never wider than 3 bits, and no X may propagate to out_imm when out_valid=0. Hold the last value, or 0 after reset/flush.

Test Plan:
1. I-type, XLEN=32, SKID=1: instr 0xFFF00093, immsrc 000 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
2. B-type: instr 0xFE000EE3 (beq -4), immsrc 011 -> out_imm=0xFFFFFFFC. U-type: instr 0x800000B7, immsrc 001 -> 0x80000000 at XLEN=32 and 0xFFFFFFFF80000000 at XLEN=64.
3. Backpressure, SKID=1: out_ready=0 for 3 cycles while offering I(0x00500093→5) then S(0xFE112E23→-4) back-to-back.
   - out_imm holds 0x5 and the S entry sits in skid.
   - in_ready=0 from the next cycle; a third offer is not accepted.
   - On out_ready=1, 0x5 then 0xFFFFFFFC emerge in order.
4. flush asserted in the same cycle as an accepted input with one entry held -> next cycle out_valid=0, in_ready=1, and neither entry ever appears on the output.
5. immsrc 111 with any instr, and immsrc 101 with instr[19:15]=5'h1F -> out_illegal=1 with out_imm=0, then out_illegal=0 with out_imm=0x1F (no sign extension).
6. rst_n pulsed low mid-stall with 2 entries held -> out_valid=0 and out_imm=0 immediately (asynchronous); after release in_ready=1, and the next input emerges with latency 1.
